seq_digit_adder: RTL

- Parametrised, digit-serial ripple-carry add/subtract unit.
- Processes DIGIT bits per clock, LSB digit first, through a DIGIT-wide full-adder chain, with the carry registered between digits.
- Trades latency for area on wide operands.
- Valid/ready handshakes on input and output; sits between operand-producing logic and result consumers in the datapath.

---
 rtl/seq_digit_adder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/seq_digit_adder.sv
// Digit-serial ripple-carry add/subtract unit: DIGIT bits per clock, LSB digit first, valid/ready on both sides.
// Optional macro SEQ_DIGIT_ADDER_ACCUM_EN adds acc_sel to reuse the held sum as operand A.
module seq_digit_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
`ifdef SEQ_DIGIT_ADDER_ACCUM_EN
   input  logic             acc_sel,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg;
   logic             in_ready_reg;
   logic             out_valid_reg;
   logic [WIDTH-1:0] a_sh_reg;
   logic [WIDTH-1:0] b_sh_reg;
   logic             carry_reg;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             cout_reg;
   logic             ovf_reg;

   logic [WIDTH-1:0] a_sh_next;
   logic [WIDTH-1:0] b_sh_next;
   logic [WIDTH-1:0] sum_next;
   logic [WIDTH-1:0] a_src;
   logic [DIGIT:0]   c_chain;
   logic [DIGIT-1:0] dig_sum;
   logic             last_digit;

`ifdef SEQ_DIGIT_ADDER_ACCUM_EN
   assign a_src = acc_sel ? sum_reg : a;
`else
   assign a_src = a;
`endif

   // DIGIT-wide full-adder chain fed by the registered inter-digit carry
   assign c_chain[0] = carry_reg;
   generate
      for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
         assign dig_sum[gi]   = a_sh_reg[gi] ^ b_sh_reg[gi] ^ c_chain[gi];
         assign c_chain[gi+1] = (a_sh_reg[gi] & b_sh_reg[gi]) |
                                (c_chain[gi] & (a_sh_reg[gi] ^ b_sh_reg[gi]));
      end
   endgenerate

   generate
      if (DIGIT < WIDTH) begin : g_multi
         localparam int RW = WIDTH - DIGIT;
         logic [RW-1:0] res_reg;
         logic [WIDTH-1:0] res_cat;

         // res_reg holds the digits finished so far, top-aligned; the last digit joins on the way out
         assign res_cat   = {dig_sum, res_reg};
         assign sum_next  = res_cat;
         assign a_sh_next = {{DIGIT{1'b0}}, a_sh_reg[WIDTH-1:DIGIT]};
         assign b_sh_next = {{DIGIT{1'b0}}, b_sh_reg[WIDTH-1:DIGIT]};

         always_ff @(posedge clk) begin
            if (!rst_n)
               res_reg <= '0;
            else if (state_reg == RUN)
               res_reg <= res_cat[WIDTH-1:DIGIT];
         end
      end else begin : g_single
         assign sum_next  = dig_sum;
         assign a_sh_next = '0;
         assign b_sh_next = '0;
      end
   endgenerate

   assign last_digit = (cnt_reg == CW'(NDIG - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         a_sh_reg      <= '0;
         b_sh_reg      <= '0;
         carry_reg     <= 1'b0;
         cnt_reg       <= '0;
         sum_reg       <= '0;
         cout_reg      <= 1'b0;
         ovf_reg       <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  a_sh_reg     <= a_src;
                  b_sh_reg     <= sub ? ~b : b;
                  carry_reg    <= sub | cin;
                  cnt_reg      <= '0;
                  state_reg    <= RUN;
                  in_ready_reg <= 1'b0;
               end
            end
            RUN: begin
               a_sh_reg  <= a_sh_next;
               b_sh_reg  <= b_sh_next;
               carry_reg <= c_chain[DIGIT];
               cnt_reg   <= cnt_reg + 1'b1;
               if (last_digit) begin
                  sum_reg       <= sum_next;
                  cout_reg      <= c_chain[DIGIT];
                  ovf_reg       <= c_chain[DIGIT] ^ c_chain[DIGIT-1];
                  state_reg     <= DONE;
                  out_valid_reg <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_reg     <= IDLE;
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg     <= IDLE;
               in_ready_reg  <= 1'b1;
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign sum       = sum_reg;
   assign cout      = cout_reg;
   assign ovf       = ovf_reg;

endmodule
